// File: rtl/uio_bus_host_if.sv
// Request/response handshake plus uio pad, strobe and ack nets of the uio register bus host.
// The host binds to the slave modport; the core-logic/pad side binds to the master modport.
interface uio_bus_host_if #(
   parameter int ADDR_W = 7
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [7:0]        req_wdata;
   logic              rsp_valid;
   logic [7:0]        rsp_rdata;
   logic              rsp_err;
   logic [7:0]        uio_out;
   logic [7:0]        uio_oe;
   logic [7:0]        uio_in;
   logic              bus_stb;
   logic              bus_ack;

   modport master (
      output req_valid, req_we, req_addr, req_wdata, uio_in, bus_ack,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err, uio_out, uio_oe, bus_stb
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, uio_in, bus_ack,
      output req_ready, rsp_valid, rsp_rdata, rsp_err, uio_out, uio_oe, bus_stb
   );
endinterface

// File: rtl/uio_bus_host.sv
// Host end of the uio pin register bus: 4-phase strobe/ack transfer of an address byte then a data byte.
// Optional macro UIO_BUS_TIMEOUT_EN adds a wait-state timeout that completes with rsp_err=1.
module uio_bus_host #(
   parameter int ADDR_W      = 7,
   parameter int SYNC_STAGES = 2,
   parameter int TURN_CYC    = 1,
   parameter int TIMEOUT_CYC = 255
) (
   input  logic          clk,
   input  logic          rst,
   uio_bus_host_if.slave bus
);
   generate
      if (ADDR_W < 1 || ADDR_W > 7) begin : g_bad_addr_w
         $error("uio_bus_host: ADDR_W must be 1..7");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("uio_bus_host: SYNC_STAGES must be >= 2");
      end
      if (TURN_CYC < 1) begin : g_bad_turn
         $error("uio_bus_host: TURN_CYC must be >= 1");
      end
      if (TIMEOUT_CYC < 1) begin : g_bad_tmo
         $error("uio_bus_host: TIMEOUT_CYC must be >= 1");
      end
   endgenerate

   typedef enum logic [3:0] {
      S_IDLE, S_A_STB, S_A_REL, S_W_STB, S_W_REL, S_TURN, S_R_STB, S_R_REL, S_RESP
   } state_t;

   localparam int TURN_W = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;

   state_t            state_q;
   logic              req_ready_q;
   logic              rsp_valid_q;
   logic [7:0]        rsp_rdata_q;
   logic [7:0]        uio_out_q;
   logic              oe_q;
   logic              stb_q;
   logic              we_q;
   logic [7:0]        wdata_q;
   logic [TURN_W-1:0] turn_q;

   logic [SYNC_STAGES-1:0] ack_sync_q;
   logic [SYNC_STAGES-1:0] ack_sync_d;
   logic                   ack_s;
   logic [6:0]             addr_ext;

   // bus_ack is asynchronous to clk; only the last sync stage may steer the FSM.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         if (gi == 0) begin : g_first
            assign ack_sync_d[gi] = bus.bus_ack;
         end else begin : g_rest
            assign ack_sync_d[gi] = ack_sync_q[gi-1];
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) ack_sync_q <= '0;
      else     ack_sync_q <= ack_sync_d;
   end

   assign ack_s = ack_sync_q[SYNC_STAGES-1];

   always_comb begin
      addr_ext              = '0;
      addr_ext[ADDR_W-1:0]  = bus.req_addr;
   end

`ifdef UIO_BUS_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYC < 256) ? 8 : $clog2(TIMEOUT_CYC + 1);

   logic [TMO_W-1:0] tmo_q;
   logic             err_q;
   logic             in_wait;
   logic             leave_wait;
   logic             tmo_hit;

   always_comb begin
      in_wait    = state_q inside {S_A_STB, S_A_REL, S_W_STB, S_W_REL, S_R_STB, S_R_REL};
      leave_wait = ((state_q inside {S_A_STB, S_W_STB, S_R_STB}) &&  ack_s) ||
                   ((state_q inside {S_A_REL, S_W_REL, S_R_REL}) && !ack_s);
   end

   assign tmo_hit = in_wait && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

   // Counts cycles spent in the current wait state; any state change restarts it.
   always_ff @(posedge clk) begin
      if (rst || !in_wait || leave_wait || tmo_hit) tmo_q <= '0;
      else                                          tmo_q <= tmo_q + TMO_W'(1);
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         uio_out_q   <= '0;
         oe_q        <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         turn_q      <= '0;
`ifdef UIO_BUS_TIMEOUT_EN
         err_q       <= 1'b0;
`endif
      end
`ifdef UIO_BUS_TIMEOUT_EN
      else if (tmo_hit) begin
         state_q     <= S_RESP;
         rsp_valid_q <= 1'b1;
         rsp_rdata_q <= '0;
         err_q       <= 1'b1;
         oe_q        <= 1'b0;
         stb_q       <= 1'b0;
      end
`endif
      else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               oe_q  <= 1'b0;
               stb_q <= 1'b0;
               if (req_ready_q && bus.req_valid) begin
                  req_ready_q <= 1'b0;
                  we_q        <= bus.req_we;
                  wdata_q     <= bus.req_wdata;
                  uio_out_q   <= {bus.req_we, addr_ext};
                  oe_q        <= 1'b1;
                  stb_q       <= 1'b1;
                  state_q     <= S_A_STB;
               end else begin
                  req_ready_q <= 1'b1;
               end
            end
            S_A_STB: if (ack_s) begin
               stb_q   <= 1'b0;
               state_q <= S_A_REL;
            end
            S_A_REL: if (!ack_s) begin
               if (we_q) begin
                  // Data byte goes out on the same edge the strobe rises.
                  uio_out_q <= wdata_q;
                  stb_q     <= 1'b1;
                  state_q   <= S_W_STB;
               end else begin
                  oe_q    <= 1'b0;
                  turn_q  <= '0;
                  state_q <= S_TURN;
               end
            end
            S_W_STB: if (ack_s) begin
               stb_q   <= 1'b0;
               state_q <= S_W_REL;
            end
            S_W_REL: if (!ack_s) begin
               oe_q        <= 1'b0;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= '0;
               state_q     <= S_RESP;
            end
            S_TURN: begin
               if (turn_q == TURN_W'(TURN_CYC - 1)) begin
                  stb_q   <= 1'b1;
                  state_q <= S_R_STB;
               end else begin
                  turn_q <= turn_q + TURN_W'(1);
               end
            end
            S_R_STB: if (ack_s) begin
               rsp_rdata_q <= bus.uio_in;
               stb_q       <= 1'b0;
               state_q     <= S_R_REL;
            end
            S_R_REL: if (!ack_s) begin
               rsp_valid_q <= 1'b1;
               state_q     <= S_RESP;
            end
            S_RESP: begin
               req_ready_q <= 1'b1;
               state_q     <= S_IDLE;
`ifdef UIO_BUS_TIMEOUT_EN
               err_q       <= 1'b0;
`endif
            end
            default: begin
               oe_q    <= 1'b0;
               stb_q   <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.uio_out   = uio_out_q;
   assign bus.uio_oe    = {8{oe_q}};
   assign bus.bus_stb   = stb_q;
`ifdef UIO_BUS_TIMEOUT_EN
   assign bus.rsp_err   = err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif
endmodule
